// File: rtl/cnn_conv3x3_core.sv
// Single-channel 3x3 valid convolution engine: streams the IFM from a 1-cycle SRAM,
// runs 9 signed MACs per output pixel, then writes ReLU/shift/saturated results to the OFM.
module cnn_conv3x3_core #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 12,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              done,
  output logic              busy,
  input  logic [71:0]       w_kernel,
  output logic              ifm_rd_en,
  output logic [ADDR_W-1:0] ifm_rd_addr,
  input  logic [7:0]        ifm_rd_data,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  output logic [7:0]        ofm_wr_data
);

  typedef enum logic [2:0] {IDLE, FETCH, ACC, WRITE, DONE} state_t;

  state_t              state;
  logic                enable_q;
  logic [ADDR_W-1:0]   ox;
  logic [ADDR_W-1:0]   oy;
  logic [ADDR_W-1:0]   ofm_cnt;
  logic [3:0]          tap;
  logic signed [19:0]  acc;

  logic [ADDR_W-1:0]   ky;
  logic [ADDR_W-1:0]   kx;
  logic [ADDR_W-1:0]   rd_addr_calc;
  logic [3:0]          w_idx;
  logic signed [7:0]   w_sel;
  logic signed [15:0]  product;
  logic signed [19:0]  product_ext;
  logic signed [19:0]  shifted;
  logic [7:0]          sat_data;
  logic                last_x;
  logic                last_y;
  logic                active;

  always_comb begin
    ky = '0;
    if (tap >= 4'd6)
      ky = ADDR_W'(2);
    else if (tap >= 4'd3)
      ky = ADDR_W'(1);
    kx = ADDR_W'(tap) - ADDR_W'(3) * ky;
    rd_addr_calc = (oy + ky) * ADDR_W'(IMG_W) + ox + kx;
  end

  // Read data lags its issue by one cycle, so the weight is selected for the previous tap.
  always_comb begin
    w_idx = (state == ACC) ? 4'd8 : (tap - 4'd1);
    w_sel = w_kernel[int'(w_idx)*8 +: 8];
    product = $signed(ifm_rd_data) * w_sel;
    product_ext = {{4{product[15]}}, product};
  end

  always_comb begin
    shifted = acc >>> SHIFT;
    sat_data = '0;
    if (acc[19])
      sat_data = '0;
    else if (shifted > 20'sd127)
      sat_data = 8'd127;
    else
      sat_data = shifted[7:0];
  end

  assign last_x = (ox == ADDR_W'(IMG_W - 3));
  assign last_y = (oy == ADDR_W'(IMG_H - 3));
  assign active = (state == FETCH) || (state == ACC) || (state == WRITE);

  // Outputs are decoded only from registered state, keeping enable off the strobe paths.
  assign busy        = active;
  assign done        = (state == DONE);
  assign ifm_rd_en   = (state == FETCH);
  assign ifm_rd_addr = (state == FETCH) ? rd_addr_calc : '0;
  assign ofm_wr_en   = (state == WRITE);
  assign ofm_wr_addr = (state == WRITE) ? ofm_cnt : '0;
  assign ofm_wr_data = (state == WRITE) ? sat_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      ox       <= '0;
      oy       <= '0;
      ofm_cnt  <= '0;
      tap      <= '0;
      acc      <= '0;
    end else begin
      enable_q <= enable;
      if (active && !enable) begin
        state   <= IDLE;
        ox      <= '0;
        oy      <= '0;
        ofm_cnt <= '0;
        tap     <= '0;
        acc     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enable && !enable_q) begin
              state   <= FETCH;
              ox      <= '0;
              oy      <= '0;
              ofm_cnt <= '0;
              tap     <= '0;
              acc     <= '0;
            end
          end
          FETCH: begin
            tap <= tap + 4'd1;
            if (tap == 4'd1)
              acc <= product_ext;
            else if (tap > 4'd1)
              acc <= acc + product_ext;
            if (tap == 4'd8)
              state <= ACC;
          end
          ACC: begin
            acc   <= acc + product_ext;
            tap   <= '0;
            state <= WRITE;
          end
          WRITE: begin
            ofm_cnt <= ofm_cnt + ADDR_W'(1);
            if (last_x) begin
              ox <= '0;
              if (last_y) begin
                oy    <= '0;
                state <= DONE;
              end else begin
                oy    <= oy + ADDR_W'(1);
                state <= FETCH;
              end
            end else begin
              ox    <= ox + ADDR_W'(1);
              state <= FETCH;
            end
          end
          DONE: begin
            if (!enable)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cnn_conv3x3_core.md
Name: cnn_conv3x3_core

Overview:
Single-channel 3x3 valid-convolution engine that sits directly downstream of the CNN ICB control register block. It consumes the level `enable` (CNNCTR[0]) and produces the level `done` (CNNSTATUS[0]). On a start it reads the input feature map (IFM) from a 1-cycle-latency SRAM and runs 9 signed MACs per output pixel. Each result is ReLU'd, shifted and saturated, then written to the output feature map (OFM) SRAM.

Parameters:
IMG_W, 8, IFM width in pixels (>=3)
IMG_H, 8, IFM height in pixels (>=3)
ADDR_W, 12, IFM/OFM address width; IMG_W*IMG_H must be <= 2^ADDR_W
SHIFT, 0, arithmetic right shift applied to accumulator before saturation (0..11)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level start/run request from control block
done  out  1  job complete; held while enable stays high
busy  out  1  engine processing (FETCH/ACC/WRITE states)
w_kernel  in  72  nine signed 8-bit weights, tap k at [8k+7:8k], k=ky*3+kx; static during a job
ifm_rd_en  out  1  IFM read strobe
ifm_rd_addr  out  ADDR_W  IFM read address
ifm_rd_data  in  8  signed IFM pixel, valid the cycle after ifm_rd_en
ofm_wr_en  out  1  OFM write strobe
ofm_wr_addr  out  ADDR_W  OFM write address
ofm_wr_data  out  8  result pixel, 0..127

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; ox, oy, tap, accumulator and OFM address counter all 0.
- Start: a rising edge of `enable` (registered previous value 0, current value 1) while in IDLE moves the engine to FETCH with ox=oy=0. A level-high `enable` alone does not restart the engine.
- States:
  - IDLE: waits for a start.
  - FETCH: lasts 9 cycles, tap k = 0..8.
  - ACC: 1 cycle.
  - WRITE: 1 cycle.
  - DONE.
- FETCH, each cycle:
  - ifm_rd_en=1.
  - ifm_rd_addr=(oy+ky)*IMG_W+(ox+kx), with ky=k/3 and kx=k%3.
  - tap increments each cycle.
- Accumulation:
  - Data for tap k arrives in the cycle after its issue.
  - For tap 0: acc <= product. For taps 1..8: acc <= acc + product.
  - The tap-8 product is accumulated in the ACC state.
  - product = signed 8x8 -> 16 bits. acc is 20-bit signed; it cannot overflow.
- WRITE:
  - ofm_wr_en=1 for exactly 1 cycle.
  - ofm_wr_addr = OFM counter, starting at 0 and incrementing by 1 per write (row-major, OFM width IMG_W-2).
  - ofm_wr_data = 0 if acc<0; else clamp(acc>>>SHIFT, 127).
- After WRITE:
  - Advance ox. At ox=IMG_W-3, wrap ox to 0 and increment oy.
  - If the pixel just written was ox=IMG_W-3 and oy=IMG_H-3, go to DONE. Otherwise go to FETCH.
- Timing: 11 cycles per output pixel. The first ifm_rd_en occurs in the cycle after the start edge is sampled.
- Total job length: (IMG_W-2)*(IMG_H-2)*11 cycles. `done` rises the cycle after the last WRITE.
- DONE: done=1, busy=0. Stays here while enable=1. When enable=0 is sampled: go to IDLE, and done falls on the next edge.
- Abort: enable=0 sampled in FETCH, ACC or WRITE:
  - Return to IDLE next cycle.
  - No further ifm_rd_en or ofm_wr_en. A write in progress completes only if it is already being driven in the current cycle.
  - done stays 0; all counters are cleared.
- Restart after abort or completion needs a new 0->1 edge on enable. The job always restarts from ox=oy=0 and OFM address 0.
- Reset mid-operation: all state is cleared immediately, asynchronously.
- Strobe timing: ifm_rd_en and ofm_wr_en are never asserted in the same cycle. Both are registered outputs or decoded purely from registered state; there is no combinational path from enable to the strobes.

Test Plan:
- IMG 4x4, SHIFT=0, all pixels 1, all weights 1, pulse enable high -> 4 writes, each data=9, addrs 0,1,2,3; first write 10 cycles after the first read; done=1 exactly 44 cycles after the start edge.
- IFM pixels = row-major index 0..15, identity kernel (tap 4 = 1, others 0), 4x4 -> outputs 5,6,9,10 at addrs 0..3; read addresses for output 0 are 0,1,2,4,5,6,8,9,10.
- All weights -1, pixels 1 -> all outputs 0 (ReLU). Pixels 127, weights 127, SHIFT=0 -> acc=145161, output 127 (saturation). Same with SHIFT=11 -> output 70.
- Abort: drop enable during FETCH of output 2 -> no further strobes, done stays 0, busy=0 next cycle; re-raise enable -> full job from read address 0, all 4 correct writes, done asserts.
- Done hold/clear: enable held high for 20 cycles after done -> done stays 1 with no new reads; enable low -> done=0 one cycle later. rst_n low mid-job -> all outputs 0 asynchronously.
